// File: rtl/led_scan_drv_if.sv
// Byte-stream link from the LED byte source into led_scan_drv.
// One byte per clock; sel_in tags it as accumulator (0) or address (1).
interface led_scan_drv_if;
  logic [7:0] data_in;
  logic       sel_in;

  modport master (output data_in, output sel_in);
  modport slave  (input  data_in, input  sel_in);
endinterface

// File: rtl/led_scan_drv.sv
// Pairs acc/addr bytes from the LED stream into display registers and scans them as
// four hex digits on a common-anode 7-segment display. Optional macro LED_SCAN_LZB_EN.
module led_scan_drv #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 50,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  led_scan_drv_if.slave      i_bus,
  output logic [6:0]         seg_n,
  output logic [3:0]         dig_n,
  output logic               frame_err,
  output logic [7:0]         disp_acc,
  output logic [7:0]         disp_addr
);

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic [1:0]       r_idx;
  logic [1:0]       w_idxNext;
  logic [6:0]       r_segN;
  logic [6:0]       w_segNext;
  logic [3:0]       r_digN;
  logic [3:0]       w_digNext;
  logic [7:0]       r_shadow;
  logic             r_pending;
  logic             r_frameErr;
  logic [7:0]       r_dispAcc;
  logic [7:0]       r_dispAddr;
  logic [3:0]       w_nibble;
  logic             w_blankDigit;
  logic             w_slotEnd;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A lone acc byte waits in the shadow so acc/addr land in the display registers together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_pending  <= 1'b0;
      r_frameErr <= 1'b0;
      r_dispAcc  <= '0;
      r_dispAddr <= '0;
    end else if (!i_bus.sel_in) begin
      r_shadow   <= i_bus.data_in;
      r_pending  <= 1'b1;
      r_frameErr <= r_pending;
    end else if (r_pending) begin
      r_dispAcc  <= r_shadow;
      r_dispAddr <= i_bus.data_in;
      r_pending  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_frameErr <= 1'b1;
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    case (r_idx)
      2'd0: w_nibble = r_dispAcc[3:0];
      2'd1: w_nibble = r_dispAcc[7:4];
      2'd2: w_nibble = r_dispAddr[3:0];
      default: w_nibble = r_dispAddr[7:4];
    endcase
  end

`ifdef LED_SCAN_LZB_EN
  // Only the high digit of each byte is a leading-zero candidate.
  assign w_blankDigit = r_idx[0] && (w_nibble == 4'h0);
`else
  assign w_blankDigit = 1'b0;
`endif

  assign w_slotEnd = (r_cnt == SLOT_LAST);
  assign w_cntNext = w_slotEnd ? '0 : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_segN  <= 7'h7F;
      r_digN  <= 4'hF;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_cntNext;
      r_idx   <= w_idxNext;
      r_segN  <= w_segNext;
      r_digN  <= w_digNext;
    end
  end

  // The digit value is sampled once at the end of blanking and held for the rest of the slot.
  always_comb begin
    w_nextState = r_state;
    w_idxNext   = r_idx;
    w_segNext   = r_segN;
    w_digNext   = r_digN;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_nextState = ST_DRIVE;
          if (!w_blankDigit) begin
            w_digNext = ~(4'b0001 << r_idx);
            w_segNext = hex7(w_nibble);
          end
        end
      end
      ST_DRIVE: begin
        if (w_slotEnd) begin
          w_nextState = ST_BLANK;
          w_idxNext   = r_idx + 2'd1;
          w_digNext   = 4'hF;
          w_segNext   = 7'h7F;
        end
      end
      default: w_nextState = ST_BLANK;
    endcase
  end

  assign seg_n     = r_segN;
  assign dig_n     = r_digN;
  assign frame_err = r_frameErr;
  assign disp_acc  = r_dispAcc;
  assign disp_addr = r_dispAddr;

endmodule
